jtag_ir_dr_shifter: RTL and testbench

- TAP data path that sits directly downstream of the TAP state machine and consumes its one-hot state outputs.
- Holds the shift and update stages of the instruction register (IR) plus three data registers: BYPASS, IDCODE and an 8-bit USER register.
- Shifts TDI in and drives TDO for the currently selected register.
- Exposes the latched instruction and the USER update value to on-chip logic.

---
 rtl/jtag_pkg.sv | 37 +++
 rtl/jtag_shift_reg.sv | 56 +++++
 rtl/jtag_ir_dr_shifter.sv | 162 ++++++++++++++++
 tb/tb_jtag_ir_dr_shifter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state encoding, default opcodes,
// IR capture pattern and the data-register select type.
package jtag_pkg;

   typedef enum logic [3:0] {
      TAP_TEST_LOGIC_RESET = 4'd0,
      TAP_RUN_TEST_IDLE    = 4'd1,
      TAP_SELECT_DR        = 4'd2,
      TAP_CAPTURE_DR       = 4'd3,
      TAP_SHIFT_DR         = 4'd4,
      TAP_EXIT1_DR         = 4'd5,
      TAP_PAUSE_DR         = 4'd6,
      TAP_EXIT2_DR         = 4'd7,
      TAP_UPDATE_DR        = 4'd8,
      TAP_SELECT_IR        = 4'd9,
      TAP_CAPTURE_IR       = 4'd10,
      TAP_SHIFT_IR         = 4'd11,
      TAP_EXIT1_IR         = 4'd12,
      TAP_PAUSE_IR         = 4'd13,
      TAP_EXIT2_IR         = 4'd14,
      TAP_UPDATE_IR        = 4'd15
   } tap_state_e;

   localparam logic [3:0] INSTR_BYPASS = 4'b1111;
   localparam logic [3:0] INSTR_IDCODE = 4'b0001;
   localparam logic [3:0] INSTR_USER   = 4'b0010;

   // Fixed low bits loaded into the IR shift stage on Capture-IR.
   localparam logic [1:0] IR_CAPTURE_PAT = 2'b01;

   typedef enum logic [1:0] {
      SEL_BYPASS = 2'd0,
      SEL_IDCODE = 2'd1,
      SEL_USER   = 2'd2
   } dr_sel_e;

endpackage

// File: rtl/jtag_shift_reg.sv
// Generic capture/shift/update register used for the IR and the USER DR.
// Shift stage shifts right with tdi_i entering the MSB; the update stage
// copies the shift stage on update_i. force_i loads force_val_i into the
// update stage and freezes the shift stage (used for Test-Logic-Reset).
module jtag_shift_reg #(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] UPD_RST_VAL = '0
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             force_i,
   input  logic [WIDTH-1:0] force_val_i,
   input  logic             capture_i,
   input  logic [WIDTH-1:0] capture_val_i,
   input  logic             shift_i,
   input  logic             tdi_i,
   input  logic             update_i,
   output logic [WIDTH-1:0] shift_o,
   output logic [WIDTH-1:0] update_o
);

   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] upd_q, upd_d;
   logic [WIDTH:0]   shift_ext;

   // Next-state: force beats capture, capture beats shift beats update.
   always_comb begin
      shift_d   = shift_q;
      upd_d     = upd_q;
      shift_ext = {tdi_i, shift_q};
      if (force_i) begin
         upd_d = force_val_i;
      end else if (capture_i) begin
         shift_d = capture_val_i;
      end else if (shift_i) begin
         shift_d = shift_ext[WIDTH:1];
      end else if (update_i) begin
         upd_d = shift_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (srst) begin
         shift_q <= '0;
         upd_q   <= UPD_RST_VAL;
      end else begin
         shift_q <= shift_d;
         upd_q   <= upd_d;
      end
   end

   assign shift_o  = shift_q;
   assign update_o = upd_q;

endmodule

// File: rtl/jtag_ir_dr_shifter.sv
// TAP data path: instruction register plus BYPASS, IDCODE and USER data
// registers, driven by the one-hot TAP state strobes.
// Optional build macro JTAG_USER_CAPTURE_EN: when defined, Capture-DR on
// USER loads USER_DR_IN (live status); otherwise it reloads USER_DR_OUT.
module jtag_ir_dr_shifter #(
   parameter int                  IR_WIDTH     = 4,
   parameter int                  DR_WIDTH     = 8,
   parameter logic [31:0]         IDCODE_VAL   = 32'h1234_5001,
   parameter logic [IR_WIDTH-1:0] INSTR_IDCODE = IR_WIDTH'(jtag_pkg::INSTR_IDCODE),
   parameter logic [IR_WIDTH-1:0] INSTR_USER   = IR_WIDTH'(jtag_pkg::INSTR_USER)
) (
   input  logic                TCK,
   input  logic                RST,
   input  logic                TDI,
   input  logic                TLR,
   input  logic                CAPTURE_DR,
   input  logic                SHIFT_DR,
   input  logic                UPDATE_DR,
   input  logic                CAPTURE_IR,
   input  logic                SHIFT_IR,
   input  logic                UPDATE_IR,
   input  logic [DR_WIDTH-1:0] USER_DR_IN,
   output logic                TDO,
   output logic                TDO_EN,
   output logic [IR_WIDTH-1:0] IR_OUT,
   output logic [DR_WIDTH-1:0] USER_DR_OUT,
   output logic                USER_UPDATE
);

   import jtag_pkg::*;

   localparam logic [IR_WIDTH-1:0] IR_CAP_VAL = IR_WIDTH'(IR_CAPTURE_PAT);

   logic                ir_strobe;
   logic                ir_capture_en, ir_shift_en, ir_update_en;
   logic                dr_allowed;
   logic [IR_WIDTH-1:0] ir_shift;
   dr_sel_e             dr_sel;

   logic                user_capture_en, user_shift_en, user_update_en;
   logic [DR_WIDTH-1:0] user_shift;
   logic [DR_WIDTH-1:0] user_cap_val;

   logic                bypass_q, bypass_d;
   logic [31:0]         id_shift_q, id_shift_d;
   logic                user_update_q;

   // TLR outranks the IR strobes, which outrank the DR strobes.
   assign ir_strobe     = CAPTURE_IR | SHIFT_IR | UPDATE_IR;
   assign ir_capture_en = CAPTURE_IR & ~TLR;
   assign ir_shift_en   = SHIFT_IR & ~TLR;
   assign ir_update_en  = UPDATE_IR & ~TLR;
   assign dr_allowed    = ~TLR & ~ir_strobe;

   jtag_shift_reg #(
      .WIDTH       (IR_WIDTH),
      .UPD_RST_VAL (INSTR_IDCODE)
   ) u_ir (
      .clk           (TCK),
      .srst          (RST),
      .force_i       (TLR),
      .force_val_i   (INSTR_IDCODE),
      .capture_i     (ir_capture_en),
      .capture_val_i (IR_CAP_VAL),
      .shift_i       (ir_shift_en),
      .tdi_i         (TDI),
      .update_i      (ir_update_en),
      .shift_o       (ir_shift),
      .update_o      (IR_OUT)
   );

   // Decode the active data register from the latched instruction.
   always_comb begin
      dr_sel = SEL_BYPASS;
      if (IR_OUT == INSTR_IDCODE) begin
         dr_sel = SEL_IDCODE;
      end else if (IR_OUT == INSTR_USER) begin
         dr_sel = SEL_USER;
      end
   end

`ifdef JTAG_USER_CAPTURE_EN
   assign user_cap_val = USER_DR_IN;
`else
   logic unused_user_dr_in;
   assign unused_user_dr_in = ^USER_DR_IN;
   assign user_cap_val      = USER_DR_OUT;
`endif

   assign user_capture_en = CAPTURE_DR & dr_allowed & (dr_sel == SEL_USER);
   assign user_shift_en   = SHIFT_DR   & dr_allowed & (dr_sel == SEL_USER);
   assign user_update_en  = UPDATE_DR  & dr_allowed & (dr_sel == SEL_USER);

   jtag_shift_reg #(
      .WIDTH       (DR_WIDTH),
      .UPD_RST_VAL ('0)
   ) u_user (
      .clk           (TCK),
      .srst          (RST),
      .force_i       (1'b0),
      .force_val_i   ('0),
      .capture_i     (user_capture_en),
      .capture_val_i (user_cap_val),
      .shift_i       (user_shift_en),
      .tdi_i         (TDI),
      .update_i      (user_update_en),
      .shift_o       (user_shift),
      .update_o      (USER_DR_OUT)
   );

   // Next-state for the inline BYPASS and IDCODE shift registers.
   always_comb begin
      bypass_d   = bypass_q;
      id_shift_d = id_shift_q;
      if (dr_allowed && dr_sel == SEL_BYPASS) begin
         if (CAPTURE_DR) begin
            bypass_d = 1'b0;
         end else if (SHIFT_DR) begin
            bypass_d = TDI;
         end
      end
      if (dr_allowed && dr_sel == SEL_IDCODE) begin
         if (CAPTURE_DR) begin
            id_shift_d = IDCODE_VAL;
         end else if (SHIFT_DR) begin
            id_shift_d = {TDI, id_shift_q[31:1]};
         end
      end
   end

   // BYPASS/IDCODE registers and the one-cycle USER update pulse.
   always_ff @(posedge TCK) begin
      if (RST) begin
         bypass_q      <= 1'b0;
         id_shift_q    <= '0;
         user_update_q <= 1'b0;
      end else begin
         bypass_q      <= bypass_d;
         id_shift_q    <= id_shift_d;
         user_update_q <= user_update_en;
      end
   end

   assign USER_UPDATE = user_update_q;

   // TDO mux: IR shift wins, then the selected DR, otherwise idle low.
   always_comb begin
      TDO = 1'b0;
      if (SHIFT_IR) begin
         TDO = ir_shift[0];
      end else if (SHIFT_DR) begin
         case (dr_sel)
            SEL_IDCODE: TDO = id_shift_q[0];
            SEL_USER:   TDO = user_shift[0];
            default:    TDO = bypass_q;
         endcase
      end
   end

   assign TDO_EN = SHIFT_IR | SHIFT_DR;

endmodule

// File: tb/tb_jtag_ir_dr_shifter.sv
// Testbench for jtag_ir_dr_shifter: directed scans followed by random
// IR/DR scans checked against a bit-stream model of the scan chain.
module tb_jtag_ir_dr_shifter;

   logic       TCK = 1'b0;
   logic       RST = 1'b1;
   logic       TDI = 1'b0;
   logic       TLR = 1'b0;
   logic       CAPTURE_DR = 1'b0, SHIFT_DR = 1'b0, UPDATE_DR = 1'b0;
   logic       CAPTURE_IR = 1'b0, SHIFT_IR = 1'b0, UPDATE_IR = 1'b0;
   logic [7:0] USER_DR_IN = 8'h00;
   logic       TDO, TDO_EN;
   logic [3:0] IR_OUT;
   logic [7:0] USER_DR_OUT;
   logic       USER_UPDATE;

   jtag_ir_dr_shifter dut (
      .TCK         (TCK),
      .RST         (RST),
      .TDI         (TDI),
      .TLR         (TLR),
      .CAPTURE_DR  (CAPTURE_DR),
      .SHIFT_DR    (SHIFT_DR),
      .UPDATE_DR   (UPDATE_DR),
      .CAPTURE_IR  (CAPTURE_IR),
      .SHIFT_IR    (SHIFT_IR),
      .UPDATE_IR   (UPDATE_IR),
      .USER_DR_IN  (USER_DR_IN),
      .TDO         (TDO),
      .TDO_EN      (TDO_EN),
      .IR_OUT      (IR_OUT),
      .USER_DR_OUT (USER_DR_OUT),
      .USER_UPDATE (USER_UPDATE)
   );

   always #5 TCK = ~TCK;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state: latched instruction and USER update value.
   logic [3:0] m_ir   = 4'b0001;
   logic [7:0] m_user = 8'h00;

   logic [63:0] st;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge TCK);
      #1;
   endtask

   function automatic bit m_is_user(input logic [3:0] ir);
      return ir == 4'b0010;
   endfunction

   function automatic int m_len(input logic [3:0] ir);
      if (ir == 4'b0001) return 32;
      if (ir == 4'b0010) return 8;
      return 1;
   endfunction

   function automatic logic [63:0] m_cap(input logic [3:0] ir);
      if (ir == 4'b0001) return 64'h1234_5001;
      if (ir == 4'b0010) begin
`ifdef JTAG_USER_CAPTURE_EN
         return {56'h0, USER_DR_IN};
`else
         return {56'h0, m_user};
`endif
      end
      return 64'h0;
   endfunction

   task automatic load_ir(input logic [3:0] op);
      logic [3:0] cap;
      cap = 4'b0001;
      CAPTURE_IR = 1'b1;
      tick();
      CAPTURE_IR = 1'b0;
      for (int i = 0; i < 4; i++) begin
         SHIFT_IR = 1'b1;
         TDI = op[i];
         #1;
         check("ir_tdo", {63'h0, TDO}, {63'h0, cap[i]});
         check("ir_hold", {60'h0, IR_OUT}, {60'h0, m_ir});
         tick();
      end
      SHIFT_IR = 1'b0;
      UPDATE_IR = 1'b1;
      tick();
      UPDATE_IR = 1'b0;
      m_ir = op;
      check("ir_out", {60'h0, IR_OUT}, {60'h0, m_ir});
   endtask

   // Capture, shift n bits, optionally update; stream s = capture then TDI.
   task automatic dr_scan(input int n, input logic [63:0] bits, input bit upd,
                          output logic [63:0] tdo_stream);
      int           len;
      bit           is_user;
      logic [127:0] s;
      len        = m_len(m_ir);
      is_user    = m_is_user(m_ir);
      s          = 128'(m_cap(m_ir)) | (128'(bits) << len);
      tdo_stream = '0;
      CAPTURE_DR = 1'b1;
      tick();
      CAPTURE_DR = 1'b0;
      for (int i = 0; i < n; i++) begin
         SHIFT_DR = 1'b1;
         TDI = bits[i];
         #1;
         check("dr_tdo", {63'h0, TDO}, {63'h0, s[i]});
         check("dr_tdo_en", {63'h0, TDO_EN}, 64'h1);
         tdo_stream[i] = TDO;
         tick();
      end
      SHIFT_DR = 1'b0;
      if (upd) begin
         UPDATE_DR = 1'b1;
         tick();
         UPDATE_DR = 1'b0;
         if (is_user) m_user = s[n +: 8];
         check("user_update", {63'h0, USER_UPDATE}, {63'h0, is_user});
         tick();
         check("user_update_end", {63'h0, USER_UPDATE}, 64'h0);
      end
      check("user_dr_out", {56'h0, USER_DR_OUT}, {56'h0, m_user});
      check("ir_after_dr", {60'h0, IR_OUT}, {60'h0, m_ir});
   endtask

   task automatic tlr_pulse();
      TLR = 1'b1;
      tick();
      TLR = 1'b0;
      m_ir = 4'b0001;
      check("tlr_ir", {60'h0, IR_OUT}, 64'h1);
      check("tlr_user", {56'h0, USER_DR_OUT}, {56'h0, m_user});
   endtask

   initial begin
      // Reset
      RST = 1'b1;
      tick();
      RST = 1'b0;
      m_ir = 4'b0001;
      m_user = 8'h00;
      check("rst_ir", {60'h0, IR_OUT}, 64'h1);
      check("rst_user", {56'h0, USER_DR_OUT}, 64'h0);
      check("rst_upd", {63'h0, USER_UPDATE}, 64'h0);
      check("rst_tdo", {63'h0, TDO}, 64'h0);
      check("rst_tdo_en", {63'h0, TDO_EN}, 64'h0);

      // IDCODE read after reset
      dr_scan(32, 64'h0, 1'b0, st);
      check("idcode_stream", st, 64'h1234_5001);

      // Select USER, write A5
      load_ir(4'b0010);
      dr_scan(8, 64'hA5, 1'b1, st);
      check("user_written", {56'h0, USER_DR_OUT}, 64'hA5);

      // Read back USER
      USER_DR_IN = 8'h3C;
      dr_scan(8, 64'h0, 1'b0, st);
`ifdef JTAG_USER_CAPTURE_EN
      check("user_readback", {56'h0, st[7:0]}, 64'h3C);
`else
      check("user_readback", {56'h0, st[7:0]}, 64'hA5);
`endif

      // BYPASS via all-ones: TDI 1,0,1,1,0 -> TDO 0,1,0,1,1
      load_ir(4'b1111);
      dr_scan(5, 64'h0D, 1'b0, st);
      check("bypass_stream", {59'h0, st[4:0]}, 64'h1A);

      // Unknown opcode acts as BYPASS, then TLR
      load_ir(4'b0111);
      dr_scan(5, 64'h0D, 1'b1, st);
      check("bypass_0111_stream", {59'h0, st[4:0]}, 64'h1A);
      tlr_pulse();

      // Reset in the middle of a USER shift
      load_ir(4'b0010);
      CAPTURE_DR = 1'b1;
      tick();
      CAPTURE_DR = 1'b0;
      for (int i = 0; i < 3; i++) begin
         SHIFT_DR = 1'b1;
         TDI = 1'b1;
         tick();
      end
      RST = 1'b1;
      tick();
      RST = 1'b0;
      SHIFT_DR = 1'b0;
      m_ir = 4'b0001;
      m_user = 8'h00;
      check("midrst_ir", {60'h0, IR_OUT}, 64'h1);
      UPDATE_DR = 1'b1;
      tick();
      UPDATE_DR = 1'b0;
      check("midrst_no_pulse", {63'h0, USER_UPDATE}, 64'h0);
      check("midrst_user", {56'h0, USER_DR_OUT}, 64'h0);
      tick();
      check("midrst_no_pulse2", {63'h0, USER_UPDATE}, 64'h0);

      // Random scans against the stream model
      for (int it = 0; it < 40; it++) begin
         logic [3:0]  op;
         logic [63:0] bits;
         int          n;
         USER_DR_IN = 8'($urandom);
         case ($urandom_range(0, 3))
            0:       op = 4'b0001;
            1:       op = 4'b0010;
            2:       op = 4'b1111;
            default: op = 4'($urandom);
         endcase
         load_ir(op);
         n = $urandom_range(1, 40);
         bits = {$urandom, $urandom};
         dr_scan(n, bits, 1'($urandom_range(0, 1)), st);
         if ($urandom_range(0, 4) == 0) tlr_pulse();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
